// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-port synchronous RAM between the IF stage
// (fetch, read-only) and the MEM stage (load/store). MEM has priority over IF.
// A port is never re-granted in the cycle its ready pulse is high.
// Optional IF starvation guard: define PIPE_MEM_ARB_STARVE_GUARD_EN.
module pipe_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WAIT_CYC   = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // IF stage
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    // MEM stage
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    // RAM side
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    // Hazard / status
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    localparam int unsigned     CNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);
    localparam logic            OWN_IF   = 1'b0;
    localparam logic            OWN_MEM  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic              busy_q, busy_d;

    logic arb_win_c;
    logic if_elig_c;
    logic mem_elig_c;
    logic force_if_c;
    logic grant_mem_c;
    logic grant_if_c;

    // Arbitration: a port whose ready is high this cycle counts as already served
    assign arb_win_c   = (state_q == S_IDLE) || (state_q == S_RESP);
    assign if_elig_c   = if_req  & ~if_ready_q;
    assign mem_elig_c  = mem_req & ~mem_ready_q;
    assign grant_mem_c = arb_win_c & mem_elig_c & ~force_if_c;
    assign grant_if_c  = arb_win_c & if_elig_c & ~grant_mem_c;

`ifdef PIPE_MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);

    logic [STV_W-1:0] starve_q, starve_d;

    // Force an IF grant once MEM has won STARVE_MAX times while IF waited
    assign force_if_c = if_elig_c & (starve_q == STV_MAX);

    // Starvation counter: counts MEM wins over a pending IF, cleared by an IF grant
    always_comb begin
        starve_d = starve_q;
        if (grant_if_c) begin
            starve_d = '0;
        end else if (grant_mem_c && if_elig_c && (starve_q != STV_MAX)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict MEM priority; IF is never forced ahead
    assign force_if_c = 1'b0;
`endif

    // Next-state and registered-output logic for the access sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;

        case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (grant_mem_c) begin
                    state_d     = S_ACCESS;
                    owner_d     = OWN_MEM;
                    cnt_d       = CNT_LOAD;
                    ram_en_d    = 1'b1;
                    ram_we_d    = mem_we;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                end else if (grant_if_c) begin
                    state_d     = S_ACCESS;
                    owner_d     = OWN_IF;
                    cnt_d       = CNT_LOAD;
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = if_addr;
                    ram_wdata_d = '0;
                end
            end
            S_ACCESS: begin
                ram_en_d = 1'b1;
                ram_we_d = ram_we_q;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    // Last RAM cycle: capture read data and schedule the ready pulse
                    state_d  = S_RESP;
                    ram_en_d = 1'b0;
                    ram_we_d = 1'b0;
                    cnt_d    = '0;
                    if (owner_q == OWN_MEM) begin
                        mem_ready_d = 1'b1;
                        if (!ram_we_q) begin
                            mem_rdata_d = ram_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_IF;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_ready = mem_ready_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;

    // Stalls follow the request combinationally and release in the ready cycle
    assign stall_if  = if_req  & ~if_ready_q;
    assign stall_mem = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: per-port scoreboards hold the
// expected read data and ready cycle; a monitor pops them on each ready pulse.
module tb_pipe_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned WC  = 2;
    localparam int unsigned SM  = 4;
    localparam int          LAT = WC + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          stall_if;
    logic          stall_mem;
    logic          busy;

    pipe_mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .WAIT_CYC  (WC),
        .STARVE_MAX(SM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            we_cycles = 0;
    exp_t          if_sb[$];
    exp_t          mem_sb[$];
    logic [DW-1:0] tb_ram  [logic [AW-1:0]];
    logic [DW-1:0] exp_mem [logic [AW-1:0]];
    logic [DW-1:0] if_done_rd = '0;
    logic [DW-1:0] mem_done_rd = '0;
    logic [DW-1:0] mem_push_rd = '0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model: one-cycle read latency, write on enable
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) tb_ram[ram_addr] = ram_wdata;
            else        ram_rdata <= tb_ram[ram_addr];
        end
    end

    // Monitor: score ready pulses, rdata hold on the other port, never-both rule
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (ram_en && ram_we) we_cycles++;
            if (if_ready || mem_ready) check_eq("one_ready", 64'(if_ready & mem_ready), 64'd0);
            if (if_ready) begin
                if (if_sb.size() == 0) begin
                    check_eq("if_unexpected_ready", 64'(if_ready), 64'd0);
                end else begin
                    e = if_sb.pop_front();
                    check_eq("if_rdata", 64'(if_rdata), 64'(e.data));
                    check_eq("if_ready_cycle", 64'(cyc), 64'(e.cyc));
                    check_eq("mem_rdata_hold", 64'(mem_rdata), 64'(mem_done_rd));
                    if_done_rd = e.data;
                end
            end
            if (mem_ready) begin
                if (mem_sb.size() == 0) begin
                    check_eq("mem_unexpected_ready", 64'(mem_ready), 64'd0);
                end else begin
                    e = mem_sb.pop_front();
                    check_eq("mem_rdata", 64'(mem_rdata), 64'(e.data));
                    check_eq("mem_ready_cycle", 64'(cyc), 64'(e.cyc));
                    check_eq("if_rdata_hold", 64'(if_rdata), 64'(if_done_rd));
                    mem_done_rd = e.data;
                end
            end
        end
    end

    // Present a fetch at the current negedge and wait for its ready (req left high)
    task automatic if_xact(input logic [AW-1:0] addr, input int lat);
        exp_t e;
        if_req  = 1'b1;
        if_addr = addr;
        e.data  = exp_mem[addr];
        e.cyc   = cyc + lat;
        if_sb.push_back(e);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_ready) begin
                check_eq("stall_if_release", 64'(stall_if), 64'd0);
                return;
            end
            check_eq("stall_if_wait", 64'(stall_if), 64'd1);
        end
        check_eq("if_timeout", 64'(if_ready), 64'd1);
    endtask

    // Present a load/store at the current negedge and wait for its ready
    task automatic mem_xact(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int lat);
        exp_t e;
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        if (we) begin
            exp_mem[addr] = wdata;
            e.data = mem_push_rd;
        end else begin
            e.data = exp_mem[addr];
            mem_push_rd = e.data;
        end
        e.cyc = cyc + lat;
        mem_sb.push_back(e);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                check_eq("stall_mem_release", 64'(stall_mem), 64'd0);
                return;
            end
            check_eq("stall_mem_wait", 64'(stall_mem), 64'd1);
        end
        check_eq("mem_timeout", 64'(mem_ready), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            tb_ram[AW'(i * 4)]  = 32'hC0DE_0000 + DW'(i);
            exp_mem[AW'(i * 4)] = 32'hC0DE_0000 + DW'(i);
        end
        tb_ram[32'h10]  = 32'h2008_0005;
        exp_mem[32'h10] = 32'h2008_0005;

        // Reset held with both requests pending: everything stays quiet
        if_req   = 1'b1;
        if_addr  = 32'h10;
        mem_req  = 1'b1;
        mem_addr = 32'h20;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_busy", 64'(busy), 64'd0);
            check_eq("rst_ram_en", 64'(ram_en), 64'd0);
        end
        check_eq("rst_if_ready", 64'(if_ready), 64'd0);
        check_eq("rst_mem_ready", 64'(mem_ready), 64'd0);
        check_eq("rst_ram_we", 64'(ram_we), 64'd0);
        check_eq("rst_ram_addr", 64'(ram_addr), 64'd0);
        check_eq("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        check_eq("rst_if_rdata", 64'(if_rdata), 64'd0);
        check_eq("rst_mem_rdata", 64'(mem_rdata), 64'd0);

        // Release with both pending: collision, MEM first then IF
        rst = 1'b1;
        fork
            begin mem_xact(1'b0, 32'h20, '0, LAT); mem_req = 1'b0; end
            begin if_xact(32'h10, 2 * LAT);        if_req  = 1'b0; end
        join
        @(negedge clk);
        check_eq("idle_after_collision", 64'(busy), 64'd0);

        // Single fetch from 0x10
        if_xact(32'h10, LAT);
        if_req = 1'b0;
        @(negedge clk);

        // Store then load at 0x40
        we_cycles = 0;
        mem_xact(1'b1, 32'h40, 32'hDEAD_BEEF, LAT);
        mem_req = 1'b0;
        check_eq("store_we_cycles", 64'(we_cycles), 64'(WC));
        check_eq("store_ram_data", 64'(tb_ram[32'h40]), 64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        mem_xact(1'b0, 32'h40, '0, LAT);
        mem_req = 1'b0;
        @(negedge clk);

        // Both ports back-to-back: the RESP-cycle exclusion alternates MEM and IF
        fork
            begin
                mem_xact(1'b0, 32'h44, '0, LAT);
                mem_xact(1'b0, 32'h48, '0, 2 * LAT);
                mem_xact(1'b0, 32'h4C, '0, 2 * LAT);
                mem_req = 1'b0;
            end
            begin
                if_xact(32'h50, 2 * LAT);
                if_xact(32'h54, 2 * LAT);
                if_xact(32'h58, 2 * LAT);
                if_req = 1'b0;
            end
        join
        @(negedge clk);

        // Reset in the first ACCESS cycle of a fetch: no ready, ram_en drops at once
        if_req  = 1'b1;
        if_addr = 32'h60;
        @(negedge clk);
        check_eq("mid_busy", 64'(busy), 64'd1);
        check_eq("mid_ram_en", 64'(ram_en), 64'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_ram_en", 64'(ram_en), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        if_done_rd  = '0;
        mem_done_rd = '0;
        mem_push_rd = '0;
        repeat (4) @(negedge clk);
        check_eq("post_rst_busy", 64'(busy), 64'd0);
        check_eq("post_rst_if_rdata", 64'(if_rdata), 64'd0);
        if_xact(32'h10, LAT);
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("if_sb_empty", 64'(if_sb.size()), 64'd0);
        check_eq("mem_sb_empty", 64'(mem_sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
